if_id_fifo: RTL and testbench

Parametrised IF/ID boundary: replaces the single-entry IF/ID latch with a DEPTH-entry fetch queue plus a registered ID output stage. It sits between the fetch unit and ID. It decouples a multi-request instruction memory from ID stalls. It tracks outstanding fetches so that wrong-path responses still in flight after a branch flush are discarded, generalising the one-shot pending-jump flag to N responses.

---
 rtl/if_id_fifo_pkg.sv | 33 +++
 rtl/if_id_buf.sv | 76 +++++++
 rtl/if_id_fifo.sv | 150 +++++++++++++++
 tb/tb_if_id_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_fifo_pkg.sv
// Shared constants and types for the IF/ID fetch queue.
// Holds the reset level, the zero word used for bubbles, the flush-source
// bit positions and the output-stage selection type.
package if_id_fifo_pkg;

  // Reset is asserted when rst equals this level
  localparam logic RST_ENABLE = 1'b1;

  // Instruction word driven to ID for a bubble
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Bit positions inside flush_i
  localparam int FLUSH_ID = 0;
  localparam int FLUSH_EX = 1;

  // What the ID output register loads at the next edge
  typedef enum logic [2:0] {
    OUT_HOLD,
    OUT_POP,
    OUT_BYPASS,
    OUT_BUBBLE,
    OUT_FLUSH
  } out_sel_e;

  // A new fetch may be issued only if every in-flight response plus every
  // queued entry still fits in the queue, so an accepted response can never
  // find the queue full.
  function automatic logic credit_ok(input int outstanding, input int queued,
                                     input int depth);
    return (outstanding + queued) < depth;
  endfunction

endpackage

// File: rtl/if_id_buf.sv
// Circular instruction queue used by if_id_fifo.
// Stores {pc, inst} entries, exposes the head entry combinationally and keeps
// an occupancy count. clear empties the queue and wins over push/pop.
// The parent guarantees no push when full and no pop when empty.
module if_id_buf
  import if_id_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop  && !clear;

  assign rd_data = mem[rd_ptr];

  // Entry storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_fifo.sv
// IF/ID boundary: fetch queue plus registered ID output stage.
// Tracks fetches still in flight so that, after a flush, responses belonging
// to the old path are dropped before any new-path response is accepted.
// Optional feature macro: IF_ID_FIFO_BYPASS_EN -- when defined, a response
// arriving with an empty queue, no stall and nothing left to drop is written
// straight into the output register (1-cycle latency). When undefined every
// accepted response goes through the queue.
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 32,
  parameter int INST_W    = 32,
  parameter int NUM_FLUSH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  output logic                 if_req_ok,
  input  logic                 if_valid,
  input  logic [ADDR_W-1:0]    if_pc,
  input  logic [INST_W-1:0]    if_inst,
  input  logic [NUM_FLUSH-1:0] flush_i,
  input  logic                 id_stall,
  output logic                 id_valid,
  output logic [ADDR_W-1:0]    id_pc,
  output logic [INST_W-1:0]    id_inst
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   buf_count;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] resp_entry;

  logic     flush_any;
  logic     resp_legal;
  logic     resp_drop;
  logic     resp_take;
  logic     bypass_take;
  logic     buf_push;
  logic     buf_pop;
  out_sel_e out_sel;

  // Any flush source squashes everything fetched on the old path
  assign flush_any = |flush_i;

  // A response with nothing outstanding is a protocol violation and ignored
  assign resp_legal = if_valid && (outstanding != '0);
  assign resp_drop  = resp_legal && (drop_cnt != '0);
  assign resp_take  = resp_legal && (drop_cnt == '0) && !flush_any;

`ifdef IF_ID_FIFO_BYPASS_EN
  assign bypass_take = resp_take && (buf_count == '0) && !id_stall;
`else
  assign bypass_take = 1'b0;
`endif

  assign buf_push   = resp_take && !bypass_take;
  assign buf_pop    = !flush_any && !id_stall && (buf_count != '0);
  assign resp_entry = {if_pc, if_inst};

  assign if_req_ok = credit_ok(int'(outstanding), int'(buf_count), DEPTH);

  if_id_buf #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (buf_push),
    .pop     (buf_pop),
    .clear   (flush_any),
    .wr_data (resp_entry),
    .rd_data (head_entry),
    .count   (buf_count)
  );

  // In-flight fetch count; flush does not change it since the memory still answers
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(if_req) - CNT_W'(resp_legal);
    end
  end

  // Drop counter is reloaded (not accumulated) on every flush with the old-path fetches still due
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      drop_cnt <= '0;
    end else if (flush_any) begin
      drop_cnt <= outstanding - CNT_W'(resp_legal);
    end else if (resp_drop) begin
      drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  // Output-stage selection: flush first, then stall, then queue head, then bypass
  always_comb begin
    out_sel = OUT_HOLD;
    if (flush_any) begin
      out_sel = OUT_FLUSH;
    end else if (id_stall) begin
      out_sel = OUT_HOLD;
    end else if (buf_count != '0) begin
      out_sel = OUT_POP;
    end else if (bypass_take) begin
      out_sel = OUT_BYPASS;
    end else begin
      out_sel = OUT_BUBBLE;
    end
  end

  // Registered ID output; a bubble is pc 0, inst zero word, valid 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= INST_W'(ZERO_WORD);
    end else begin
      case (out_sel)
        OUT_POP: begin
          id_valid <= 1'b1;
          id_pc    <= head_entry[ENTRY_W-1:INST_W];
          id_inst  <= head_entry[INST_W-1:0];
        end
        OUT_BYPASS: begin
          id_valid <= 1'b1;
          id_pc    <= if_pc;
          id_inst  <= if_inst;
        end
        OUT_BUBBLE, OUT_FLUSH: begin
          id_valid <= 1'b0;
          id_pc    <= '0;
          id_inst  <= INST_W'(ZERO_WORD);
        end
        default: begin
          id_valid <= id_valid;
          id_pc    <= id_pc;
          id_inst  <= id_inst;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed testbench for if_id_fifo (DEPTH=4, 32-bit PC and instruction).
// Expected latencies follow IF_ID_FIFO_BYPASS_EN when that macro is defined.
module tb_if_id_fifo;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic        if_req_ok;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  flush_i;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int total;
  int bad;

  if_id_fifo #(
    .DEPTH     (4),
    .ADDR_W    (32),
    .INST_W    (32),
    .NUM_FLUSH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_req_ok (if_req_ok),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .flush_i   (flush_i),
    .id_stall  (id_stall),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction word the bench attaches to each fetched PC
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  task automatic apply_stimulus(input logic req, input logic valid,
                                input logic [31:0] pc, input logic [1:0] flush,
                                input logic stall);
    if_req   = req;
    if_valid = valid;
    if_pc    = valid ? pc : 32'h0;
    if_inst  = valid ? inst_of(pc) : 32'h0;
    flush_i  = flush;
    id_stall = stall;
  endtask

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_instr(input string tag, input logic [31:0] pc);
    check_output({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
    check_output({tag, "_pc"}, id_pc, pc);
    check_output({tag, "_inst"}, id_inst, inst_of(pc));
  endtask

  task automatic check_bubble(input string tag);
    check_output({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);

    // Reset values
    #3;
    check_output("rst_valid", {31'b0, id_valid}, 32'd0);
    check_output("rst_pc", id_pc, 32'h0);
    check_output("rst_inst", id_inst, 32'h0);
    check_output("rst_req_ok", {31'b0, if_req_ok}, 32'd1);
    #9;
    rst = 1'b0;

    // First fetch latency: request cycle 0, response cycle 2
    apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    check_output("lat_req_ok", {31'b0, if_req_ok}, 32'd1);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h100, 2'b00, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef IF_ID_FIFO_BYPASS_EN
    check_instr("lat_c3", 32'h100);
    tick();
    check_bubble("lat_c4");
`else
    check_bubble("lat_c3");
    tick();
    check_instr("lat_c4", 32'h100);
    tick();
    check_bubble("lat_c5");
`endif

    // Credit limit with ID stalled
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
      tick();
      if (i == 2) check_output("cred_ok_3", {31'b0, if_req_ok}, 32'd1);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_output("cred_ok_4", {31'b0, if_req_ok}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'h100 + 32'(4 * i), 2'b00, 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_output("cred_full_ok", {31'b0, if_req_ok}, 32'd0);
    check_bubble("cred_stalled");
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_instr("cred_pop", 32'h100 + 32'(4 * i));
      if (i == 0) check_output("cred_ok_after_pop", {31'b0, if_req_ok}, 32'd1);
    end
    tick();
    check_bubble("cred_drained");

    // Flush with 3 outstanding; the flush-cycle response is discarded
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
      tick();
    end
    apply_stimulus(1'b1, 1'b1, 32'hDEAD0, 2'b01, 1'b0);
    tick();
    check_bubble("fl_edge");
    apply_stimulus(1'b0, 1'b1, 32'h300, 2'b00, 1'b0);
    tick();
    check_bubble("fl_drop1");
    apply_stimulus(1'b0, 1'b1, 32'h304, 2'b00, 1'b0);
    tick();
    check_bubble("fl_drop2");
    apply_stimulus(1'b0, 1'b1, 32'h200, 2'b00, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef IF_ID_FIFO_BYPASS_EN
    check_instr("fl_new", 32'h200);
`else
    check_bubble("fl_wait");
    tick();
    check_instr("fl_new", 32'h200);
`endif
    tick();
    check_bubble("fl_after");
    check_output("fl_req_ok", {31'b0, if_req_ok}, 32'd1);

    // EX flush while stalled with two entries queued
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'h400 + 32'(4 * i), 2'b00, 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    check_instr("exf_before", 32'h400);
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b10, 1'b1);
    tick();
    check_bubble("exf_edge");
    check_output("exf_pc", id_pc, 32'h0);
    check_output("exf_inst", id_inst, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    check_bubble("exf_empty");
    check_output("exf_req_ok", {31'b0, if_req_ok}, 32'd1);

    // Back-to-back flushes with 2 outstanding: drop count must stay 2
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b01, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b10, 1'b0);
    tick();
    check_bubble("b2b_edge");
    apply_stimulus(1'b0, 1'b1, 32'h700, 2'b00, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h704, 2'b00, 1'b0);
    tick();
    check_bubble("b2b_drop");
    apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h500, 2'b00, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef IF_ID_FIFO_BYPASS_EN
    check_instr("b2b_new", 32'h500);
`else
    check_bubble("b2b_wait");
    tick();
    check_instr("b2b_new", 32'h500);
`endif
    tick();
    check_bubble("b2b_after");

    // Asynchronous reset mid-cycle with three entries queued
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'h800 + 32'(4 * i), 2'b00, 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    check_instr("ar_before", 32'h800);
    apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_output("ar_req_ok_before", {31'b0, if_req_ok}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_bubble("ar_mid");
    check_output("ar_pc", id_pc, 32'h0);
    check_output("ar_req_ok", {31'b0, if_req_ok}, 32'd1);
    #1;
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    check_bubble("ar_empty");

    // Stale response after reset has nothing outstanding and is ignored
    apply_stimulus(1'b0, 1'b1, 32'h900, 2'b00, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    check_bubble("pv_ignored");
    check_output("pv_req_ok", {31'b0, if_req_ok}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
      tick();
    end
    apply_stimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    check_output("pv_credit_3", {31'b0, if_req_ok}, 32'd1);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_output("pv_credit_4", {31'b0, if_req_ok}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'hA00 + 32'(4 * i), 2'b00, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef IF_ID_FIFO_BYPASS_EN
    check_instr("pv_stream", 32'hA0C);
`else
    check_instr("pv_stream", 32'hA08);
    tick();
    check_instr("pv_stream_last", 32'hA0C);
`endif
    tick();
    check_bubble("pv_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
